// File: rtl/keypad_pkg.sv
// Shared types and key-map helpers for the 6x4 calculator keypad front end.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;
  typedef enum logic [1:0] {HEX, OP, EQ, NONE} key_class_t;

  localparam int NUM_ROWS = 6;
  localparam int NUM_COLS = 4;
  localparam int ROW_OPS  = 4;
  localparam int ROW_EQ   = 5;
  localparam int COL_EQ   = 0;

  // Rows below the operator row are hex digits; row 5 holds only the equals key.
  function automatic key_class_t key_class(input logic [2:0] r, input logic [1:0] c);
    key_class_t k;
    if (r < 3'(ROW_OPS))
      k = HEX;
    else if (r == 3'(ROW_OPS))
      k = OP;
    else if (r == 3'(ROW_EQ) && c == 2'(COL_EQ))
      k = EQ;
    else
      k = NONE;
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all ones so idle active-low lines read as released.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Scans the key matrix, debounces press and release, and emits one pulse per accepted key.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SETTLE          = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] col_n,
  input  logic [5:0] row_n,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq
);

  localparam int CNT_MAX = (SETTLE > DEBOUNCE_CYCLES) ? SETTLE : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_ROWS-1:0] rows_s;
  state_t              state, state_nx;
  logic [1:0]          col, col_nx;
  logic [2:0]          row, row_nx;
  logic [CNT_W-1:0]    settle_cnt, settle_nx;
  logic [CNT_W-1:0]    deb_cnt, deb_nx;
  logic [3:0]          hexcode_nx;
  logic [1:0]          opcode_nx;
  logic                any_low;
  logic [2:0]          low_row;
  logic                held_ok;
  logic                pulse;
  key_class_t          cls;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clock (clock),
    .reset (reset),
    .d     (row_n),
    .q     (rows_s)
  );

  // Lowest-index low row wins when several keys in the driven column are down.
  always_comb begin
    any_low = 1'b0;
    low_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_s[i]) begin
        any_low = 1'b1;
        low_row = 3'(i);
      end
    end
  end

  assign held_ok = !rows_s[row] && (low_row == row);
  assign cls     = key_class(row, col);

  always_comb begin
    state_nx   = state;
    col_nx     = col;
    row_nx     = row;
    settle_nx  = settle_cnt;
    deb_nx     = deb_cnt;
    hexcode_nx = hexcode;
    opcode_nx  = opcode;
    case (state)
      SCAN: begin
        if (settle_cnt < SETTLE_V) begin
          settle_nx = settle_cnt + 1'b1;
        end else if (any_low) begin
          row_nx   = low_row;
          deb_nx   = '0;
          state_nx = DEBOUNCE;
        end else begin
          col_nx    = col + 2'd1;
          settle_nx = '0;
        end
      end
      DEBOUNCE: begin
        if (held_ok) begin
          if (deb_cnt >= DEB_LAST) begin
            // Codes load on the entry edge so they are stable alongside the pulse.
            state_nx = EMIT;
            deb_nx   = '0;
            case (cls)
              HEX:     hexcode_nx = {row[1:0], col};
              OP:      opcode_nx  = col;
              default: ;
            endcase
          end else begin
            deb_nx = deb_cnt + 1'b1;
          end
        end else begin
          state_nx  = SCAN;
          settle_nx = '0;
          deb_nx    = '0;
        end
      end
      EMIT: begin
        state_nx = WAIT_RELEASE;
        deb_nx   = '0;
      end
      WAIT_RELEASE: begin
        if (rows_s[row]) begin
          if (deb_cnt >= DEB_LAST) begin
            state_nx  = SCAN;
            col_nx    = col + 2'd1;
            settle_nx = '0;
            deb_nx    = '0;
          end else begin
            deb_nx = deb_cnt + 1'b1;
          end
        end else begin
          deb_nx = '0;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SCAN;
      col        <= '0;
      row        <= '0;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      hexcode    <= '0;
      opcode     <= '0;
    end else begin
      state      <= state_nx;
      col        <= col_nx;
      row        <= row_nx;
      settle_cnt <= settle_nx;
      deb_cnt    <= deb_nx;
      hexcode    <= hexcode_nx;
      opcode     <= opcode_nx;
    end
  end

  // Gating with reset suppresses a pulse whose EMIT clock coincides with reset.
  assign pulse  = (state == EMIT) && !reset;
  assign newhex = pulse && (cls == HEX);
  assign newop  = pulse && (cls == OP);
  assign eq     = pulse && (cls == EQ);
  assign col_n  = ~(4'b0001 << col);

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: key-matrix model, event scoreboard, directed and random presses.
module tb_keypad_encoder;

  localparam int K_NONE = -1;
  localparam int K_HEX  = 0;
  localparam int K_OP   = 1;
  localparam int K_EQ   = 2;

  typedef struct {
    int kind;
    int code;
  } event_t;

  typedef struct {
    int r;
    int c;
    int kind;
    int code;
    int hexc;
    int opc;
  } tv_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_n;
  logic [5:0] row_n;
  logic       newhex, newop, eq;
  logic [3:0] hexcode;
  logic [1:0] opcode;

  logic [3:0] pressed [6];
  event_t     seen [$];
  int         multi_pulse = 0;
  int         tests = 0;
  int         failed = 0;
  tv_t        vectors [7];

  keypad_encoder #(.SETTLE(2), .DEBOUNCE_CYCLES(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .col_n   (col_n),
    .row_n   (row_n),
    .newhex  (newhex),
    .hexcode (hexcode),
    .newop   (newop),
    .opcode  (opcode),
    .eq      (eq)
  );

  always #5 clock = ~clock;

  // A row reads low whenever any pressed key in it sits in the driven column.
  always_comb begin
    for (int r = 0; r < 6; r++)
      row_n[r] = ~|(pressed[r] & ~col_n);
  end

  always @(negedge clock) begin
    if ((32'(newhex) + 32'(newop) + 32'(eq)) > 1)
      multi_pulse++;
    if (newhex) seen.push_back('{K_HEX, int'(hexcode)});
    if (newop)  seen.push_back('{K_OP, int'(opcode)});
    if (eq)     seen.push_back('{K_EQ, 0});
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic level);
    pressed[r][c] = level;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_col_start(input logic [3:0] target, input string name);
    logic [3:0] prev;
    int found;
    found = 0;
    prev  = col_n;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clock);
      if (col_n == target && prev != target) found = 1;
      prev = col_n;
    end
    checkOutput(name, found, 1);
  endtask

  // Reference key map, written from the keypad layout rather than the encoder logic.
  function automatic int model_kind(input int r, input int c);
    if (r <= 3) return K_HEX;
    if (r == 4) return K_OP;
    if (r == 5 && c == 0) return K_EQ;
    return K_NONE;
  endfunction

  function automatic int model_code(input int r, input int c);
    if (r <= 3) return r * 4 + c;
    if (r == 4) return c;
    return 0;
  endfunction

  initial begin
    logic [3:0] exp_col;
    logic [3:0] col_mask;
    int exp_hex, exp_op, r, c, k, hold, gap;

    vectors[0] = '{2, 3, K_HEX, 11, 11, 0};
    vectors[1] = '{5, 0, K_EQ,  0,  11, 0};
    vectors[2] = '{4, 2, K_OP,  2,  11, 2};
    vectors[3] = '{5, 2, K_NONE, 0, 11, 2};
    vectors[4] = '{0, 0, K_HEX, 0,  0,  2};
    vectors[5] = '{3, 3, K_HEX, 15, 15, 2};
    vectors[6] = '{4, 3, K_OP,  3,  15, 3};

    for (int i = 0; i < 6; i++) pressed[i] = 4'b0000;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Idle scan: each column held for SETTLE plus one sample clock.
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      exp_col = 4'b1111;
      exp_col[(i / 3) % 4] = 1'b0;
      checkOutput($sformatf("idle_col_%0d", i), int'(col_n), int'(exp_col));
    end
    checkOutput("idle_no_pulse", seen.size(), 0);
    checkOutput("idle_hexcode", int'(hexcode), 0);
    checkOutput("idle_opcode", int'(opcode), 0);

    for (int v = 0; v < 7; v++) begin
      seen.delete();
      applyStimulus(vectors[v].r, vectors[v].c, 1'b1);
      tick(50);
      checkOutput($sformatf("vec%0d_held_events", v), seen.size(), (vectors[v].kind == K_NONE) ? 0 : 1);
      applyStimulus(vectors[v].r, vectors[v].c, 1'b0);
      tick(30);
      checkOutput($sformatf("vec%0d_events", v), seen.size(), (vectors[v].kind == K_NONE) ? 0 : 1);
      if (vectors[v].kind != K_NONE && seen.size() > 0) begin
        checkOutput($sformatf("vec%0d_kind", v), seen[0].kind, vectors[v].kind);
        checkOutput($sformatf("vec%0d_code", v), seen[0].code, vectors[v].code);
      end
      checkOutput($sformatf("vec%0d_hexcode", v), int'(hexcode), vectors[v].hexc);
      checkOutput($sformatf("vec%0d_opcode", v), int'(opcode), vectors[v].opc);
    end

    col_mask = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      col_mask = col_mask | ~col_n;
    end
    checkOutput("scan_resumes", int'(col_mask), 15);

    // Press bounce on (4,1), then a release bounce.
    seen.delete();
    wait_col_start(4'b1101, "bounce_col_wait");
    applyStimulus(4, 1, 1'b1); tick(3);
    applyStimulus(4, 1, 1'b0); tick(1);
    applyStimulus(4, 1, 1'b1); tick(3);
    checkOutput("bounce_no_pulse", seen.size(), 0);
    tick(40);
    checkOutput("bounce_events", seen.size(), 1);
    if (seen.size() > 0) begin
      checkOutput("bounce_kind", seen[0].kind, K_OP);
      checkOutput("bounce_code", seen[0].code, 1);
    end
    checkOutput("bounce_opcode", int'(opcode), 1);
    applyStimulus(4, 1, 1'b0); tick(2);
    applyStimulus(4, 1, 1'b1); tick(10);
    applyStimulus(4, 1, 1'b0); tick(30);
    checkOutput("release_bounce_events", seen.size(), 1);

    // Two rows in one column, then a second key while the first is held.
    seen.delete();
    applyStimulus(1, 0, 1'b1);
    applyStimulus(3, 0, 1'b1);
    tick(50);
    checkOutput("multi_events", seen.size(), 1);
    if (seen.size() > 0) checkOutput("multi_code", seen[0].code, 4);
    checkOutput("multi_hexcode", int'(hexcode), 4);
    applyStimulus(3, 0, 1'b0);
    applyStimulus(0, 2, 1'b1);
    tick(60);
    checkOutput("rollover_blocked", seen.size(), 1);
    applyStimulus(1, 0, 1'b0);
    tick(60);
    checkOutput("rollover_after_release", seen.size(), 2);
    if (seen.size() > 1) checkOutput("rollover_code", seen[1].code, 2);
    checkOutput("rollover_hexcode", int'(hexcode), 2);
    applyStimulus(0, 2, 1'b0);
    tick(30);

    // Reset while debouncing (2,3).
    seen.delete();
    wait_col_start(4'b0111, "rst_deb_col_wait");
    applyStimulus(2, 3, 1'b1);
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(2, 3, 1'b0);
    @(negedge clock);
    checkOutput("rst_deb_col", int'(col_n), 14);
    checkOutput("rst_deb_no_pulse", seen.size(), 0);
    checkOutput("rst_deb_hexcode", int'(hexcode), 0);
    checkOutput("rst_deb_opcode", int'(opcode), 0);

    // Reset on the EMIT clock of (3,3): pulse suppressed, code cleared.
    wait_col_start(4'b0111, "rst_emit_col_wait");
    applyStimulus(3, 3, 1'b1);
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    checkOutput("rst_emit_hexcode_loaded", int'(hexcode), 15);
    @(posedge clock);
    #1 reset = 1'b0;
    applyStimulus(3, 3, 1'b0);
    @(negedge clock);
    checkOutput("rst_emit_col", int'(col_n), 14);
    checkOutput("rst_emit_no_pulse", seen.size(), 0);
    checkOutput("rst_emit_hexcode", int'(hexcode), 0);
    tick(30);
    checkOutput("rst_emit_still_quiet", seen.size(), 0);

    // Random presses with short lead-in bounce, scored against the key map.
    exp_hex = 0;
    exp_op  = 0;
    for (int n = 0; n < 10; n++) begin
      r    = int'($urandom_range(0, 5));
      c    = int'($urandom_range(0, 3));
      hold = int'($urandom_range(40, 70));
      gap  = int'($urandom_range(20, 35));
      seen.delete();
      applyStimulus(r, c, 1'b1); tick(int'($urandom_range(1, 2)));
      applyStimulus(r, c, 1'b0); tick(1);
      applyStimulus(r, c, 1'b1); tick(hold);
      applyStimulus(r, c, 1'b0); tick(gap);
      k = model_kind(r, c);
      if (k == K_HEX) exp_hex = model_code(r, c);
      if (k == K_OP)  exp_op  = model_code(r, c);
      checkOutput($sformatf("rand%0d_events_r%0d_c%0d", n, r, c), seen.size(), (k == K_NONE) ? 0 : 1);
      if (k != K_NONE && seen.size() > 0) begin
        checkOutput($sformatf("rand%0d_kind", n), seen[0].kind, k);
        checkOutput($sformatf("rand%0d_code", n), seen[0].code, model_code(r, c));
      end
      checkOutput($sformatf("rand%0d_hexcode", n), int'(hexcode), exp_hex);
      checkOutput($sformatf("rand%0d_opcode", n), int'(opcode), exp_op);
    end

    checkOutput("one_pulse_per_clock", multi_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
